// File: rtl/rf_ex_reg.sv
// RF->EX pipeline register for the LEGv8 core, with load-use bubble insertion.
// Optional RF_EX_PERF_CNT_EN adds lu_bubble_cnt, a count of inserted load-use bubbles.
module rf_ex_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned ZR_IDX = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_valid,
  input  logic [63:0]       rf_imm,
  input  logic [63:0]       rf_rdata1,
  input  logic [63:0]       rf_rdata2,
  input  logic [4:0]        rf_rn,
  input  logic [4:0]        rf_rm,
  input  logic              rf_uses_rn,
  input  logic              rf_uses_rm,
  input  logic [4:0]        rf_rd,
  input  logic              rf_mem_read,
  input  logic              rf_reg_write,
  input  logic [CTRL_W-1:0] rf_ctrl,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              rf_stall,
  output logic              ex_valid,
  output logic [63:0]       ex_imm,
  output logic [63:0]       ex_rdata1,
  output logic [63:0]       ex_rdata2,
  output logic [4:0]        ex_rd,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef RF_EX_PERF_CNT_EN
  ,
  output logic [31:0]       lu_bubble_cnt
`endif
);

  localparam logic [4:0] ZR = 5'(ZR_IDX);

  logic lu_hz;

  always_comb begin
    lu_hz = ex_valid & ex_mem_read & (ex_rd != ZR) & rf_valid &
            ((rf_uses_rn & (rf_rn == ex_rd)) | (rf_uses_rm & (rf_rm == ex_rd)));
    rf_stall = ex_stall | (lu_hz & ~flush);
  end

  // A bubble clears only the valid and side-effect controls; datapath fields keep their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_imm       <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (flush || (!ex_stall && lu_hz)) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (!ex_stall) begin
      ex_valid     <= rf_valid;
      ex_imm       <= rf_imm;
      ex_rdata1    <= rf_rdata1;
      ex_rdata2    <= rf_rdata2;
      ex_rd        <= rf_rd;
      ex_mem_read  <= rf_valid & rf_mem_read;
      ex_reg_write <= rf_valid & rf_reg_write;
      ex_ctrl      <= rf_valid ? rf_ctrl : '0;
    end
  end

`ifdef RF_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lu_bubble_cnt <= '0;
    else if (lu_hz && !flush && !ex_stall)
      lu_bubble_cnt <= lu_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rf_ex_reg.sv
// Directed self-checking bench for rf_ex_reg; checks lu_bubble_cnt when RF_EX_PERF_CNT_EN is defined.
module tb_rf_ex_reg;

  localparam int unsigned CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rf_valid;
  logic [63:0]       rf_imm;
  logic [63:0]       rf_rdata1;
  logic [63:0]       rf_rdata2;
  logic [4:0]        rf_rn;
  logic [4:0]        rf_rm;
  logic              rf_uses_rn;
  logic              rf_uses_rm;
  logic [4:0]        rf_rd;
  logic              rf_mem_read;
  logic              rf_reg_write;
  logic [CTRL_W-1:0] rf_ctrl;
  logic              ex_stall;
  logic              flush;
  logic              rf_stall;
  logic              ex_valid;
  logic [63:0]       ex_imm;
  logic [63:0]       ex_rdata1;
  logic [63:0]       ex_rdata2;
  logic [4:0]        ex_rd;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef RF_EX_PERF_CNT_EN
  logic [31:0]       lu_bubble_cnt;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  rf_ex_reg #(.CTRL_W(CTRL_W), .ZR_IDX(31)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rf_valid     (rf_valid),
    .rf_imm       (rf_imm),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .rf_rn        (rf_rn),
    .rf_rm        (rf_rm),
    .rf_uses_rn   (rf_uses_rn),
    .rf_uses_rm   (rf_uses_rm),
    .rf_rd        (rf_rd),
    .rf_mem_read  (rf_mem_read),
    .rf_reg_write (rf_reg_write),
    .rf_ctrl      (rf_ctrl),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .rf_stall     (rf_stall),
    .ex_valid     (ex_valid),
    .ex_imm       (ex_imm),
    .ex_rdata1    (ex_rdata1),
    .ex_rdata2    (ex_rdata2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_ctrl      (ex_ctrl)
`ifdef RF_EX_PERF_CNT_EN
    ,
    .lu_bubble_cnt(lu_bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_set(input logic v, input logic [63:0] imm, input logic [63:0] d1,
                        input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                        input logic urm, input logic [4:0] rd, input logic mr,
                        input logic rw, input logic [CTRL_W-1:0] ctrl);
    rf_valid = v; rf_imm = imm; rf_rdata1 = d1; rf_rdata2 = d1 + 64'd1;
    rf_rn = rn; rf_uses_rn = urn; rf_rm = rm; rf_uses_rm = urm;
    rf_rd = rd; rf_mem_read = mr; rf_reg_write = rw; rf_ctrl = ctrl;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    rf_set(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_imm", ex_imm, 64'd0);
    chk("rst_ctrl", {48'd0, ex_ctrl}, 64'd0);
    chk("rst_stall", {63'd0, rf_stall}, 64'd0);
    step(); step();
    rst_n = 1'b1;

    // Basic load into EX
    rf_set(1'b1, 64'h10, 64'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 16'hA5A5);
    step();
    chk("ld_valid", {63'd0, ex_valid}, 64'd1);
    chk("ld_imm", ex_imm, 64'h10);
    chk("ld_rdata1", ex_rdata1, 64'd5);
    chk("ld_rdata2", ex_rdata2, 64'd6);
    chk("ld_rd", {59'd0, ex_rd}, 64'd3);
    chk("ld_rw", {63'd0, ex_reg_write}, 64'd1);
    chk("ld_mr", {63'd0, ex_mem_read}, 64'd0);
    chk("ld_ctrl", {48'd0, ex_ctrl}, 64'hA5A5);

    // LDUR X2 followed by dependent ADD on Rn
    rf_set(1'b1, 64'h20, 64'd100, 5'd7, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 16'h0F0F);
    step();
    chk("ldur_mr", {63'd0, ex_mem_read}, 64'd1);
    chk("ldur_rd", {59'd0, ex_rd}, 64'd2);
    rf_set(1'b1, 64'h30, 64'd11, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 16'h1234);
    #1;
    chk("lu_stall", {63'd0, rf_stall}, 64'd1);
    step();
    chk("bub_valid", {63'd0, ex_valid}, 64'd0);
    chk("bub_mr", {63'd0, ex_mem_read}, 64'd0);
    chk("bub_rw", {63'd0, ex_reg_write}, 64'd0);
    chk("bub_ctrl", {48'd0, ex_ctrl}, 64'd0);
    chk("bub_imm_hold", ex_imm, 64'h20);
    chk("bub_rd_hold", {59'd0, ex_rd}, 64'd2);
    chk("bub_stall_clr", {63'd0, rf_stall}, 64'd0);
`ifdef RF_EX_PERF_CNT_EN
    chk("cnt_1", {32'd0, lu_bubble_cnt}, 64'd1);
`endif
    step();
    chk("add_valid", {63'd0, ex_valid}, 64'd1);
    chk("add_rd", {59'd0, ex_rd}, 64'd5);
    chk("add_imm", ex_imm, 64'h30);
    chk("add_ctrl", {48'd0, ex_ctrl}, 64'h1234);

    // Load to XZR is never a hazard source
    rf_set(1'b1, 64'h38, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 16'h0001);
    step();
    chk("zr_ld_rd", {59'd0, ex_rd}, 64'd31);
    rf_set(1'b1, 64'h40, 64'd1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd6, 1'b0, 1'b1, 16'h0002);
    #1;
    chk("zr_nostall", {63'd0, rf_stall}, 64'd0);
    step();
    chk("zr_valid", {63'd0, ex_valid}, 64'd1);
    chk("zr_rd", {59'd0, ex_rd}, 64'd6);

    // Matching Rm but not used -> no hazard
    rf_set(1'b1, 64'h48, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 16'h0003);
    step();
    rf_set(1'b1, 64'h50, 64'd2, 5'd1, 1'b1, 5'd4, 1'b0, 5'd7, 1'b0, 1'b1, 16'h0004);
    #1;
    chk("rm_unused_nostall", {63'd0, rf_stall}, 64'd0);
    step();
    chk("rm_unused_rd", {59'd0, ex_rd}, 64'd7);
    chk("rm_unused_valid", {63'd0, ex_valid}, 64'd1);

    // Three-cycle downstream stall
    ex_stall = 1'b1;
    rf_set(1'b1, 64'h60, 64'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 16'h0005);
    #1;
    chk("xs_stall0", {63'd0, rf_stall}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("xs_imm_hold", ex_imm, 64'h50);
      chk("xs_rd_hold", {59'd0, ex_rd}, 64'd7);
      chk("xs_ctrl_hold", {48'd0, ex_ctrl}, 64'h0004);
      chk("xs_stall", {63'd0, rf_stall}, 64'd1);
    end
    ex_stall = 1'b0;
    step();
    chk("xs_release_imm", ex_imm, 64'h60);
    chk("xs_release_rd", {59'd0, ex_rd}, 64'd8);

    // flush + ex_stall + load-use (hazard through Rm)
    rf_set(1'b1, 64'h70, 64'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 16'hBEEF);
    step();
    chk("fl_ld_mr", {63'd0, ex_mem_read}, 64'd1);
    rf_set(1'b1, 64'h80, 64'd5, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b0, 1'b1, 16'h0006);
    #1;
    chk("rm_hz_stall", {63'd0, rf_stall}, 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_hz_nostall", {63'd0, rf_stall}, 64'd0);
    ex_stall = 1'b1;
    #1;
    chk("flush_xs_stall", {63'd0, rf_stall}, 64'd1);
    step();
    chk("fl_valid", {63'd0, ex_valid}, 64'd0);
    chk("fl_rw", {63'd0, ex_reg_write}, 64'd0);
    chk("fl_ctrl", {48'd0, ex_ctrl}, 64'd0);
    chk("fl_imm_hold", ex_imm, 64'h70);
    flush = 1'b0; ex_stall = 1'b0;
    step();
    chk("post_fl_rd", {59'd0, ex_rd}, 64'd10);
    chk("post_fl_imm", ex_imm, 64'h80);
`ifdef RF_EX_PERF_CNT_EN
    chk("cnt_no_flush_count", {32'd0, lu_bubble_cnt}, 64'd1);
`endif

    // Load-use during ex_stall: hold, then bubble once stall drops
    rf_set(1'b1, 64'h88, 64'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 16'h0007);
    step();
    rf_set(1'b1, 64'h90, 64'd7, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b1, 16'h0008);
    ex_stall = 1'b1;
    step();
    chk("xs_hz_rd", {59'd0, ex_rd}, 64'd12);
    chk("xs_hz_mr", {63'd0, ex_mem_read}, 64'd1);
    chk("xs_hz_stall", {63'd0, rf_stall}, 64'd1);
    ex_stall = 1'b0;
    #1;
    chk("hz_after_xs_stall", {63'd0, rf_stall}, 64'd1);
    step();
    chk("bub2_valid", {63'd0, ex_valid}, 64'd0);
`ifdef RF_EX_PERF_CNT_EN
    chk("cnt_2", {32'd0, lu_bubble_cnt}, 64'd2);
`endif
    step();
    chk("dep2_rd", {59'd0, ex_rd}, 64'd13);
    chk("dep2_valid", {63'd0, ex_valid}, 64'd1);

    // Invalid slot carries no side-effect controls
    rf_set(1'b0, 64'hA0, 64'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 16'hFFFF);
    step();
    chk("inv_valid", {63'd0, ex_valid}, 64'd0);
    chk("inv_mr", {63'd0, ex_mem_read}, 64'd0);
    chk("inv_rw", {63'd0, ex_reg_write}, 64'd0);
    chk("inv_ctrl", {48'd0, ex_ctrl}, 64'd0);
    chk("inv_imm", ex_imm, 64'hA0);

    // Asynchronous reset between edges
    rf_set(1'b1, 64'hB0, 64'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 16'h0009);
    step();
    chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ex_valid}, 64'd0);
    chk("arst_imm", ex_imm, 64'd0);
    chk("arst_rdata1", ex_rdata1, 64'd0);
    chk("arst_rd", {59'd0, ex_rd}, 64'd0);
    chk("arst_mr", {63'd0, ex_mem_read}, 64'd0);
    chk("arst_ctrl", {48'd0, ex_ctrl}, 64'd0);
    chk("arst_stall", {63'd0, rf_stall}, 64'd0);
`ifdef RF_EX_PERF_CNT_EN
    chk("arst_cnt", {32'd0, lu_bubble_cnt}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_ex_reg.md
Name: rf_ex_reg

Overview:
- Pipeline register between the register-fetch (RF) stage and the execute (EX) stage of the pipelined LEGv8 core.
- Captures the selected 64-bit immediate, both register read operands, the destination register and the control bundle.
- Detects load-use hazards against the instruction currently in EX and inserts a one-cycle bubble while stalling RF.
- Honours downstream stall and pipeline flush requests.

Parameters:
- CTRL_W, 16, width of the opaque EX/MEM/WB control bundle carried through unchanged.
- ZR_IDX, 31, register index of XZR; never a hazard source.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rf_valid  input  1  RF stage holds a real instruction
- rf_imm  input  64  selected, extended immediate from RF
- rf_rdata1  input  64  register read port 1 data (Rn)
- rf_rdata2  input  64  register read port 2 data (Rm/Rt)
- rf_rn  input  5  source register 1 index
- rf_rm  input  5  source register 2 index
- rf_uses_rn  input  1  instruction reads rf_rn
- rf_uses_rm  input  1  instruction reads rf_rm
- rf_rd  input  5  destination register index
- rf_mem_read  input  1  instruction is a load
- rf_reg_write  input  1  instruction writes the register file
- rf_ctrl  input  CTRL_W  remaining control bundle
- ex_stall  input  1  EX cannot accept; hold register contents
- flush  input  1  squash the instruction entering EX (branch redirect)
- rf_stall  output  1  upstream must hold PC and IF/RF register this cycle
- ex_valid  output  1  EX holds a real instruction
- ex_imm  output  64  registered immediate
- ex_rdata1  output  64  registered operand 1
- ex_rdata2  output  64  registered operand 2
- ex_rd  output  5  registered destination index
- ex_mem_read  output  1  registered load flag
- ex_reg_write  output  1  registered register-write flag
- ex_ctrl  output  CTRL_W  registered control bundle

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs go to 0. ex_valid, ex_mem_read, ex_reg_write and ex_ctrl are 0; data fields and ex_rd are 0.
- Hazard signal (combinational): lu_hz = ex_valid & ex_mem_read & (ex_rd != ZR_IDX) & rf_valid & ((rf_uses_rn & rf_rn==ex_rd) | (rf_uses_rm & rf_rm==ex_rd)).
- rf_stall = ex_stall | (lu_hz & ~flush); purely combinational, no registered latency.
- Per-edge update priority, highest first:
  1. flush: load a bubble.
  2. ex_stall: hold every register.
  3. lu_hz: load a bubble.
  4. Otherwise: load all rf_* fields, with ex_valid = rf_valid.
- Bubble: ex_valid, ex_mem_read, ex_reg_write and ex_ctrl are forced to 0. ex_imm, ex_rdata1, ex_rdata2 and ex_rd hold their previous values.
- If rf_valid=0 on a normal load, ex_mem_read, ex_reg_write and ex_ctrl are also loaded as 0, so an invalid slot never carries side-effect controls.
- Latency: one cycle from RF to EX. A load-use pair costs exactly one bubble: the bubble clears lu_hz on the next cycle and the dependent instruction then advances.
- flush together with ex_stall: flush wins and EX becomes a bubble on that edge.
- flush together with lu_hz: bubble, and rf_stall is deasserted so the redirect proceeds.
- ex_stall together with lu_hz: hold, and rf_stall stays asserted. The hazard is re-evaluated once ex_stall drops.
- Reset asserted mid-stall or mid-bubble returns immediately to the reset state. No pending bubble survives reset.

Optional Feature:
- Macro: RF_EX_PERF_CNT_EN.
- With the macro defined:
  - Adds output lu_bubble_cnt (32 bits) counting edges where a load-use bubble is inserted (lu_hz & ~flush & ~ex_stall).
  - The counter wraps from 0xFFFFFFFF to 0 and is cleared by reset.
- Without the macro: the port and the counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then apply rf_valid=1, rf_imm=0x10, rf_rdata1=5, rf_rd=3, rf_reg_write=1 -> after one edge: ex_valid=1, ex_imm=0x10, ex_rdata1=5, ex_rd=3, ex_reg_write=1.
- LDUR X2 in EX (ex_mem_read=1, ex_rd=2), RF has ADD with rf_rn=2, rf_uses_rn=1 -> rf_stall=1 the same cycle; next edge ex_valid=0, ex_mem_read=0; following edge the ADD is in EX and rf_stall=0.
- Load to X31 in EX with RF reading X31 -> rf_stall=0 and no bubble. Load to X4 with RF rf_rm=4 but rf_uses_rm=0 -> no bubble.
- ex_stall=1 for 3 cycles while RF presents new data -> ex_* outputs unchanged for 3 edges; rf_stall=1 throughout.
- flush=1 together with ex_stall=1 and lu_hz=1 -> next edge ex_valid=0, ex_reg_write=0, ex_ctrl=0; rf_stall=1 only because of ex_stall.
- rst_n pulled low mid-operation asynchronously (between edges) -> all outputs read 0 immediately. With RF_EX_PERF_CNT_EN defined, two load-use bubbles give lu_bubble_cnt=2 and reset returns it to 0.
